// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative MIPS multiply/divide sequencer:
// ISA widths, op and FSM encodings, and two's-complement helpers.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [2*XLEN-1:0] neg64(input logic [2*XLEN-1:0] x);
        return ~x + 64'd1;
    endfunction

    // -2^31 maps onto itself, which is the wanted magnitude 0x80000000.
    function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] x, input logic is_signed);
        if (is_signed && x[XLEN-1]) begin
            return neg32(x);
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Pipeline-side bundle of the mul/div sequencer: launch, MTHI/MTLO writes,
// and the status/HI/LO return path.
interface muldiv_seq_if;
    import muldiv_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            wr_hi;
    logic            wr_lo;
    logic [XLEN-1:0] wd;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wd,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// Single 33-bit adder/subtractor shared by the multiply add and the
// divide trial-subtract; cout=1 on subtract means no borrow.
module muldiv_step (
    input  logic [32:0] x,
    input  logic [32:0] y,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        cout
);

    logic [32:0] y_eff_s;

    // Invert the second operand for subtraction; the carry-in completes it.
    always_comb begin
        if (sub) begin
            y_eff_s = ~y;
        end else begin
            y_eff_s = y;
        end
        {cout, sum} = {1'b0, x} + {1'b0, y_eff_s} + {33'd0, sub};
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: 32 shift-add or
// restoring-divide iterations followed by one sign-fix cycle.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);

    logic [1:0]      state_r, state_nx_s;
    logic [4:0]      cnt_r, cnt_nx_s;
    logic [32:0]     acc_r, acc_nx_s;
    logic [XLEN-1:0] mplr_r, mplr_nx_s;
    logic [XLEN-1:0] mcand_r, mcand_nx_s;
    logic            is_div_r, is_div_nx_s;
    logic            neg_res_r, neg_res_nx_s;
    logic            neg_rem_r, neg_rem_nx_s;
    logic [XLEN-1:0] hi_r, hi_nx_s;
    logic [XLEN-1:0] lo_r, lo_nx_s;
    logic            busy_r, busy_nx_s;
    logic            done_r, done_nx_s;

    logic [32:0]     rem_sh_s;
    logic [32:0]     step_x_s;
    logic [32:0]     step_sum_s;
    logic            step_cout_s;
    logic [32:0]     add_s;
    logic [2*XLEN-1:0] prod_s;
    logic            op_signed_s;

    // acc doubles as the remainder and mplr as the quotient during divide.
    assign rem_sh_s    = {acc_r[31:0], mplr_r[31]};
    assign op_signed_s = ~bus.op[0];
    assign prod_s      = {acc_r[31:0], mplr_r};

    // Route the shared adder: plain add for multiply, trial-subtract for divide.
    always_comb begin
        if (is_div_r) begin
            step_x_s = rem_sh_s;
        end else begin
            step_x_s = acc_r;
        end
    end

    muldiv_step u_step (
        .x    (step_x_s),
        .y    ({1'b0, mcand_r}),
        .sub  (is_div_r),
        .sum  (step_sum_s),
        .cout (step_cout_s)
    );

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        acc_nx_s     = acc_r;
        mplr_nx_s    = mplr_r;
        mcand_nx_s   = mcand_r;
        is_div_nx_s  = is_div_r;
        neg_res_nx_s = neg_res_r;
        neg_rem_nx_s = neg_rem_r;
        hi_nx_s      = hi_r;
        lo_nx_s      = lo_r;
        add_s        = acc_r;

        // MTHI/MTLO land on this edge even when a start is also accepted.
        if (!busy_r) begin
            if (bus.wr_hi) begin
                hi_nx_s = bus.wd;
            end else begin
                hi_nx_s = hi_r;
            end
            if (bus.wr_lo) begin
                lo_nx_s = bus.wd;
            end else begin
                lo_nx_s = lo_r;
            end
        end else begin
            hi_nx_s = hi_r;
            lo_nx_s = lo_r;
        end

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_nx_s   = ST_RUN;
                    cnt_nx_s     = 5'd0;
                    is_div_nx_s  = bus.op[1];
                    neg_res_nx_s = op_signed_s & (bus.a[31] ^ bus.b[31]);
                    neg_rem_nx_s = op_signed_s & bus.a[31];
                    acc_nx_s     = 33'd0;
                    if (bus.op[1]) begin
                        mplr_nx_s  = mag32(bus.a, op_signed_s);
                        mcand_nx_s = mag32(bus.b, op_signed_s);
                    end else begin
                        mplr_nx_s  = mag32(bus.b, op_signed_s);
                        mcand_nx_s = mag32(bus.a, op_signed_s);
                    end
                end else if (state_r == ST_DONE) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_nx_s = cnt_r + 5'd1;
                if (is_div_r) begin
                    if (step_cout_s) begin
                        acc_nx_s  = step_sum_s;
                        mplr_nx_s = {mplr_r[30:0], 1'b1};
                    end else begin
                        acc_nx_s  = rem_sh_s;
                        mplr_nx_s = {mplr_r[30:0], 1'b0};
                    end
                end else begin
                    if (mplr_r[0]) begin
                        add_s = step_sum_s;
                    end else begin
                        add_s = acc_r;
                    end
                    acc_nx_s  = {1'b0, add_s[32:1]};
                    mplr_nx_s = {add_s[0], mplr_r[31:1]};
                end
                if (cnt_r == 5'(ITER - 1)) begin
                    state_nx_s = ST_FIX;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FIX: begin
                state_nx_s = ST_DONE;
                if (is_div_r) begin
                    lo_nx_s = neg_res_r ? neg32(mplr_r) : mplr_r;
                    hi_nx_s = neg_rem_r ? neg32(acc_r[31:0]) : acc_r[31:0];
                end else if (neg_res_r) begin
                    {hi_nx_s, lo_nx_s} = neg64(prod_s);
                end else begin
                    {hi_nx_s, lo_nx_s} = prod_s;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        busy_nx_s = (state_nx_s == ST_RUN) || (state_nx_s == ST_FIX);
        done_nx_s = (state_nx_s == ST_DONE);
    end

    // State and datapath registers; reset aborts with no partial HI/LO update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 5'd0;
            acc_r     <= 33'd0;
            mplr_r    <= 32'd0;
            mcand_r   <= 32'd0;
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            acc_r     <= acc_nx_s;
            mplr_r    <= mplr_nx_s;
            mcand_r   <= mcand_nx_s;
            is_div_r  <= is_div_nx_s;
            neg_res_r <= neg_res_nx_s;
            neg_rem_r <= neg_rem_nx_s;
            hi_r      <= hi_nx_s;
            lo_r      <= lo_nx_s;
            busy_r    <= busy_nx_s;
            done_r    <= done_nx_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: vector table plus hand-written
// sequences for reset abort, MTHI/MTLO gating, ignored start and back-to-back.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   lat;
    vec_t vecs[13];
    vec_t v;

    always #5 clk = ~clk;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge E0.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (bus.done !== 1'b1 && n < 60) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    // kind 1: stray start at cycle inj; kind 2: MTHI at cycle inj while busy.
    task automatic run_op(input vec_t tv, input int inj, input int kind);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int n;
        prev_hi = bus.hi;
        prev_lo = bus.lo;
        launch(tv.op, tv.a, tv.b);
        chk({tv.name, " busy"}, {31'd0, bus.busy}, 32'd1);
        n = 1;
        while (bus.done !== 1'b1 && n < 60) begin
            if (n == inj && kind == 1) begin
                bus.start = 1'b1;
                bus.op    = OP_MULTU;
                bus.a     = 32'd5;
                bus.b     = 32'd5;
            end
            if (n == inj && kind == 2) begin
                bus.wr_hi = 1'b1;
                bus.wd    = 32'h0000dead;
            end
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            bus.wr_hi = 1'b0;
            n++;
            if (kind == 2 && n == inj + 1) chk({tv.name, " hi busy write"}, bus.hi, prev_hi);
            if (n == 20) begin
                chk({tv.name, " hi hold"}, bus.hi, prev_hi);
                chk({tv.name, " lo hold"}, bus.lo, prev_lo);
            end
        end
        chk({tv.name, " latency"}, 32'(n), 32'd34);
        chk({tv.name, " hi"}, bus.hi, tv.hi);
        chk({tv.name, " lo"}, bus.lo, tv.lo);
    endtask

    initial begin
        vecs[0]  = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_m3x7",   OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"div_m7d2",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_7d0",    OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[4]  = '{"div_m7d0",    OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
        vecs[5]  = '{"div_7d0",     OP_DIV,   32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[6]  = '{"div_min_m1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7]  = '{"mult_minsq",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{"mult_m1m1",   OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[9]  = '{"div_7dm2",    OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{"div_m7dm2",   OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vecs[11] = '{"mult_7xm3",   OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[12] = '{"multu_shift", OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wd    = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i], 0, 0);
        end

        // Abort mid-RUN: asynchronous clear, then a clean DIVU.
        launch(OP_DIVU, 32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        chk("abort hi", bus.hi, 32'd0);
        chk("abort lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        v = '{"divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14};
        run_op(v, 0, 0);

        // MTHI / MTLO while idle.
        @(negedge clk);
        bus.wr_hi = 1'b1;
        bus.wd    = 32'h00001234;
        @(posedge clk);
        @(negedge clk);
        bus.wr_hi = 1'b0;
        chk("mthi idle", bus.hi, 32'h00001234);
        bus.wr_lo = 1'b1;
        bus.wd    = 32'h00005678;
        @(posedge clk);
        @(negedge clk);
        bus.wr_lo = 1'b0;
        chk("mtlo idle", bus.lo, 32'h00005678);
        chk("mtlo keeps hi", bus.hi, 32'h00001234);

        run_op(vecs[1], 10, 2);
        @(negedge clk);
        run_op(vecs[1], 10, 1);

        // Start and MTLO in the same cycle: the write lands, FIX overwrites.
        @(negedge clk);
        bus.wr_lo = 1'b1;
        bus.wd    = 32'h0000abcd;
        launch(OP_DIVU, 32'd100, 32'd7);
        bus.wr_lo = 1'b0;
        chk("start+mtlo lo", bus.lo, 32'h0000abcd);
        wait_done(lat);
        chk("start+mtlo latency", 32'(lat), 32'd34);
        chk("start+mtlo hi", bus.hi, 32'd2);
        chk("start+mtlo lo final", bus.lo, 32'd14);

        // Back-to-back: second start in the DONE cycle.
        repeat (2) @(negedge clk);
        done_cnt = 0;
        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat);
        chk("b2b first latency", 32'(lat), 32'd34);
        chk("b2b first lo", bus.lo, 32'h00000001);
        launch(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
        chk("b2b no gap busy", {31'd0, bus.busy}, 32'd1);
        wait_done(lat);
        chk("b2b second latency", 32'(lat), 32'd34);
        chk("b2b second hi", bus.hi, 32'hFFFFFFFF);
        chk("b2b second lo", bus.lo, 32'hFFFFFFFD);
        repeat (3) @(negedge clk);
        chk("b2b done pulses", 32'(done_cnt), 32'd2);
        chk("b2b idle done", {31'd0, bus.done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
